// File: rtl/wb_trace_pkg.sv
// ============================================================================
// Module      : wb_trace_pkg
// Description : Shared types and constants for the writeback trace serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_trace_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_trace_entry_t;

    localparam logic [3:0] TRACE_WEN_ALL = 4'hF;

endpackage

`default_nettype wire

// File: rtl/wb_trace_fifo.sv
// ============================================================================
// Module      : wb_trace_fifo
// Description : Two-write / one-read circular buffer of trace entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_a,
    input  wb_trace_entry_t        push_a_entry,
    input  logic                   push_b,
    input  wb_trace_entry_t        push_b_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output wb_trace_entry_t        head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_b;
    logic [CW-1:0]   count_q, count_d;
    wb_trace_entry_t mem_q [DEPTH];

    // push_b is only ever asserted together with push_a, so it lands one slot later.
    always_comb begin
        wr_ptr_b = wr_ptr_q + PW'(1);
        wr_ptr_d = wr_ptr_q + PW'(push_a) + PW'(push_b);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_a) begin
            mem_q[wr_ptr_q] <= push_a_entry;
        end
        if (push_b) begin
            mem_q[wr_ptr_b] <= push_b_entry;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/wb_trace_serializer.sv
// ============================================================================
// Module      : wb_trace_serializer
// Description : Serializes two writeback lanes into one in-order debug trace
//               port. Define WB_TRACE_FILTER_R0_EN to drop writes to r0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_serializer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb0_en,
    input  logic [4:0]  wb0_rd,
    input  logic [31:0] wb0_data,
    input  logic [31:0] wb0_pc,
    input  logic        wb1_en,
    input  logic [4:0]  wb1_rd,
    input  logic [31:0] wb1_data,
    input  logic [31:0] wb1_pc,
    output logic        stall_req,
    output logic        overflow,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic            lane0_valid, lane1_valid;
    wb_trace_entry_t lane0_entry, lane1_entry, head_entry;
    wb_trace_entry_t push_a_entry, push_b_entry;
    logic [CW-1:0]   count, free_slots;
    logic            pop, lane0_push, lane1_push, push_a, push_b, drop;

    logic            overflow_q, overflow_d;
    logic            out_valid_q, out_valid_d;
    wb_trace_entry_t out_entry_q, out_entry_d;

`ifdef WB_TRACE_FILTER_R0_EN
    assign lane0_valid = wb0_en && (wb0_rd != 5'd0);
    assign lane1_valid = wb1_en && (wb1_rd != 5'd0);
`else
    assign lane0_valid = wb0_en;
    assign lane1_valid = wb1_en;
`endif

    assign lane0_entry = '{rd: wb0_rd, data: wb0_data, pc: wb0_pc};
    assign lane1_entry = '{rd: wb1_rd, data: wb1_data, pc: wb1_pc};

    // Space is judged after this cycle's pop, so a draining FIFO can still take a push.
    always_comb begin
        pop          = (count != '0);
        free_slots   = DEPTH_C - (count - CW'(pop));
        lane0_push   = lane0_valid && (free_slots != '0);
        lane1_push   = lane1_valid && (free_slots > (lane0_push ? CW'(1) : CW'(0)));
        drop         = (lane0_valid && !lane0_push) || (lane1_valid && !lane1_push);
        push_a       = lane0_push || lane1_push;
        push_b       = lane0_push && lane1_push;
        push_a_entry = lane0_push ? lane0_entry : lane1_entry;
        push_b_entry = lane1_entry;
    end

    wb_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_a       (push_a),
        .push_a_entry (push_a_entry),
        .push_b       (push_b),
        .push_b_entry (push_b_entry),
        .pop          (pop),
        .count        (count),
        .head         (head_entry)
    );

    always_comb begin
        overflow_d  = overflow_q | drop;
        out_valid_d = pop;
        out_entry_d = pop ? head_entry : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    assign stall_req         = (DEPTH_C - count) < CW'(2);
    assign overflow          = overflow_q;
    assign debug_wb_pc       = out_entry_q.pc;
    assign debug_wb_rf_wen   = out_valid_q ? TRACE_WEN_ALL : 4'h0;
    assign debug_wb_rf_wnum  = out_entry_q.rd;
    assign debug_wb_rf_wdata = out_entry_q.data;

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_serializer.sv
// ============================================================================
// Module      : tb_wb_trace_serializer
// Description : Randomized self-checking bench for wb_trace_serializer against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_trace_serializer;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb0_en, wb1_en;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb0_pc, wb1_data, wb1_pc;
    logic        stall_req, overflow;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    wb_trace_serializer #(.DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .wb0_en            (wb0_en),
        .wb0_rd            (wb0_rd),
        .wb0_data          (wb0_data),
        .wb0_pc            (wb0_pc),
        .wb1_en            (wb1_en),
        .wb1_rd            (wb1_rd),
        .wb1_data          (wb1_data),
        .wb1_pc            (wb1_pc),
        .stall_req         (stall_req),
        .overflow          (overflow),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    ent_t exp_out;
    bit   exp_valid;
    bit   exp_ovf;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lane_counts(input logic en, input logic [4:0] rd);
`ifdef WB_TRACE_FILTER_R0_EN
        return en && (rd != 5'd0);
`else
        return en && (rd == rd);
`endif
    endfunction

    function automatic bit model_stall();
        return (DEPTH - q.size()) < 2;
    endfunction

    // One clock edge of the trace: oldest entry leaves, then lane 0 and lane 1 try to enter.
    task automatic model_edge();
        int free;
        if (q.size() > 0) begin
            exp_out   = q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_out   = '{rd: 5'd0, data: 32'd0, pc: 32'd0};
            exp_valid = 1'b0;
        end
        free = DEPTH - q.size();
        if (lane_counts(wb0_en, wb0_rd)) begin
            if (free > 0) begin
                q.push_back('{rd: wb0_rd, data: wb0_data, pc: wb0_pc});
                free--;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (lane_counts(wb1_en, wb1_rd)) begin
            if (free > 0) begin
                q.push_back('{rd: wb1_rd, data: wb1_data, pc: wb1_pc});
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("wen",   32'(debug_wb_rf_wen),  exp_valid ? 32'hF : 32'h0);
        check("wnum",  32'(debug_wb_rf_wnum), 32'(exp_out.rd));
        check("wdata", debug_wb_rf_wdata,     exp_out.data);
        check("pc",    debug_wb_pc,           exp_out.pc);
        check("stall", 32'(stall_req),        32'(model_stall()));
        check("ovf",   32'(overflow),         32'(exp_ovf));
    endtask

    task automatic cycle(input bit e0, input logic [4:0] r0, input logic [31:0] d0, input logic [31:0] p0,
                         input bit e1, input logic [4:0] r1, input logic [31:0] d1, input logic [31:0] p1);
        wb0_en = e0; wb0_rd = r0; wb0_data = d0; wb0_pc = p0;
        wb1_en = e1; wb1_rd = r1; wb1_data = d1; wb1_pc = p1;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        end
    endtask

    task automatic dual(input logic [31:0] base);
        cycle(1'b1, base[4:0] | 5'd1, base ^ 32'h5A5A0000, base,
              1'b1, base[4:0] | 5'd2, base ^ 32'hA5A50000, base + 32'd4);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_out   = '{rd: 5'd0, data: 32'd0, pc: 32'd0};
        reset     = 1'b1;
        wb0_en = 1'b0; wb0_rd = 5'd0; wb0_data = 32'd0; wb0_pc = 32'd0;
        wb1_en = 1'b0; wb1_rd = 5'd0; wb1_data = 32'd0; wb1_pc = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        #3 reset = 1'b0;

        // Lane 0 alone: visible on the second cycle, gone on the third.
        cycle(1'b1, 5'd3, 32'h12345678, 32'hBFC00000, 1'b0, 5'd0, 32'd0, 32'd0);
        idle(1);
        check("l0_pc",   debug_wb_pc,          32'hBFC00000);
        check("l0_wnum", 32'(debug_wb_rf_wnum), 32'd3);
        check("l0_data", debug_wb_rf_wdata,    32'h12345678);
        idle(1);
        check("l0_idle", 32'(debug_wb_rf_wen),  32'h0);

        // Dual push appears lane 0 then lane 1 on consecutive cycles.
        cycle(1'b1, 5'd5, 32'h55, 32'hBFC00010, 1'b1, 5'd6, 32'h66, 32'hBFC00014);
        idle(1);
        check("dual_pc0", debug_wb_pc, 32'hBFC00010);
        idle(1);
        check("dual_pc1", debug_wb_pc, 32'hBFC00014);
        idle(1);

        // Dual push until stall, then drain honoring it: no overflow, order through wrap.
        for (int i = 0; i < 10 && !stall_req; i++) begin
            dual(32'h8000_0000 + 32'(i) * 8);
        end
        check("stall_cnt", 32'(q.size()), 32'd7);
        idle(DEPTH + 1);
        check("no_ovf", 32'(overflow), 32'd0);

        // Ignore stall: overflow sets and stays, survivors remain ordered.
        for (int i = 0; i < 12; i++) begin
            dual(32'h9000_0000 + 32'(i) * 8);
        end
        check("ovf_set", 32'(overflow), 32'd1);
        idle(DEPTH + 1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // r0 write alongside an r7 write.
        cycle(1'b1, 5'd0, 32'hD0, 32'hC0, 1'b1, 5'd7, 32'hD7, 32'hC4);
        idle(1);
`ifdef WB_TRACE_FILTER_R0_EN
        check("r0_first", 32'(debug_wb_rf_wnum), 32'd7);
`else
        check("r0_first", 32'(debug_wb_rf_wnum), 32'd0);
        idle(1);
        check("r0_second", 32'(debug_wb_rf_wnum), 32'd7);
`endif
        idle(2);

        // Asynchronous reset with entries buffered.
        for (int i = 0; i < 3; i++) begin
            dual(32'hA000_0000 + 32'(i) * 8);
        end
        check("pre_rst_cnt", 32'(q.size()), 32'd4);
        #2 reset = 1'b1;
        #1;
        q.delete();
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_out   = '{rd: 5'd0, data: 32'd0, pc: 32'd0};
        check_outputs();
        @(posedge clock);
        #3 reset = 1'b0;
        idle(4);

        // Randomized traffic, mostly honoring stall.
        for (int i = 0; i < 400; i++) begin
            bit          hold;
            bit          e0, e1;
            logic [4:0]  r0, r1;
            hold = model_stall() && ($urandom_range(0, 7) != 0);
            e0 = !hold && ($urandom_range(0, 2) != 0);
            e1 = !hold && ($urandom_range(0, 2) != 0);
            r0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            r1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            cycle(e0, r0, $urandom, $urandom, e1, r1, $urandom, $urandom);
        end
        idle(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_trace_serializer.md
# wb_trace_serializer

Converts the dual-issue writeback stage's two per-cycle register-write channels into one in-order, one-write-per-cycle debug trace port (`debug_wb_pc` / `debug_wb_rf_wen` / `debug_wb_rf_wnum` / `debug_wb_rf_wdata`). The single-lane golden-trace comparator consumes this port. It sits between the datapath's writeback stage and the SoC debug outputs. Entries are buffered in a small circular FIFO, and the block requests a writeback stall when the FIFO cannot absorb a dual write.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries. Power of two, ≥4.

Ports:
- `clock`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-high.
- `wb0_en`, input, 1: lane 0 register write valid. Lane 0 is always older.
- `wb0_rd`, input, 5: lane 0 destination register.
- `wb0_data`, input, 32: lane 0 write data.
- `wb0_pc`, input, 32: lane 0 instruction PC.
- `wb1_en`, `wb1_rd`, `wb1_data`, `wb1_pc`: input, 1/5/32/32. Lane 1, same meaning, younger than lane 0.
- `stall_req`, output, 1: FIFO cannot accept two pushes next cycle. Writeback must hold.
- `overflow`, output, 1: sticky flag. Set when a push was dropped for lack of space.
- `debug_wb_pc`, output, 32: PC of the trace entry presented this cycle. 0 when idle.
- `debug_wb_rf_wen`, output, 4: 4'hF when an entry is presented, else 4'h0.
- `debug_wb_rf_wnum`, output, 5: register number of the presented entry. 0 when idle.
- `debug_wb_rf_wdata`, output, 32: data of the presented entry. 0 when idle.

## Operation
- Per cycle, the block makes up to 2 pushes (lane 0 first, then lane 1) and 1 pop.
- Push order is lane 0 then lane 1. Lane 1 alone pushes into the first free slot.
- A pop happens whenever the FIFO is non-empty at the clock edge. There is no downstream backpressure: the trace port is fire-and-forget.
- Occupancy: `count_next = count + pushes − pop`. `count` width is clog2(DEPTH)+1.
- Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Space check uses `count − pop`, so a same-cycle pop frees a slot for a push.
- If space is 1 and both lanes are valid:
  - lane 0 is stored, lane 1 is dropped, and `overflow` is set.
  - If lane 1 alone is valid with space 0, it is dropped and `overflow` is set.
- `stall_req` is combinational from registered `count`: `(DEPTH − count) < 2`.
- `overflow` clears only on reset.
- The output stage is a register loaded from the FIFO head on pop and loaded with zeros when nothing pops.

## Timing
- Reset values: all outputs 0, pointers 0, `count` 0, `overflow` 0.
- Latency is 1 cycle. A push at edge N can appear on the debug port for the cycle after edge N+1 (FIFO write at N, head popped at N+1).
- Throughput is 1 entry per cycle. Dual pushes on consecutive cycles grow `count` by 1 per cycle.
- Simultaneous push, pop and wrap: the write pointer wraps from DEPTH−1 to 0 within the same cycle as the read pointer advances, with no bubble.
- Empty with a single push: the entry is output exactly 1 cycle later. It is never bypassed in the same cycle.
- Reset asserted mid-operation: all buffered entries are discarded, and the outputs go to 0 asynchronously.

## Configuration
- Macro `WB_TRACE_FILTER_R0_EN`.
- Defined: a lane with `rd == 0` does not push, does not count toward space, and never sets `overflow`.
- Undefined: writes to r0 are pushed and traced like any other register.

## Structure
- Package `wb_trace_pkg`:
  - typedef `wb_trace_entry_t` (rd 5, data 32, pc 32, packed)
  - localparam `TRACE_WEN_ALL = 4'hF`
- Sub-module `wb_trace_fifo`: a 2-write/1-read circular buffer with `count` and pointers.
- The top level holds push/filter logic, `stall_req`, `overflow`, and the output register.

## Test plan
- Lane 0 only (pc 0xBFC00000, rd 3, data 0x12345678). The next cycle but one shows wen F, wnum 3, that data and that pc. The following cycle shows all zeros.
- Dual push (lane 0: pc 0xBFC00010, rd 5; lane 1: pc 0xBFC00014, rd 6). The output shows pc 0x…10, then pc 0x…14 on consecutive cycles.
- DEPTH=8 with dual pushes every cycle. `stall_req` asserts when `count` reaches 7. Holding the inputs off while stalled gives no `overflow`, and 8 entries drain in order across pointer wrap.
- Ignore `stall_req` and keep dual-pushing. On the first lost entry `overflow` goes to 1 and stays 1. Surviving entries are still in order.
- With `WB_TRACE_FILTER_R0_EN` defined, lane 0 rd 0 and lane 1 rd 7 on the same cycle: only rd 7 appears. Without the macro, rd 0 appears followed by rd 7.
- Assert `reset` with 4 entries buffered. Outputs are 0 immediately. After release, the debug port stays idle until a new push.
